// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and the NOP
// that fills the output slot after reset.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   // addi x0, x0, 0
   localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-to-decode output slot: one instruction plus its PC under valid/ready.
interface instruction_fetch_unit_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32
);
   logic                  if_valid;
   logic                  if_ready;
   logic [ADDR_WIDTH-1:0] if_pc;
   logic [INST_WIDTH-1:0] if_instr;

   modport master (output if_valid, if_pc, if_instr, input if_ready);
   modport slave  (input if_valid, if_pc, if_instr, output if_ready);
endinterface

// File: rtl/instruction_fetch_unit_pc_gen.sv
// Next-PC selection for the fetch stage: a redirect beats sequential advance,
// and with neither the PC holds.
module fetch_pc_gen #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] pc_q,
   input  logic                  redirect_en,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   input  logic                  advance_en,
   output logic [ADDR_WIDTH-1:0] pc_d
);

   always_comb begin
      pc_d = pc_q;
      if (redirect_en) begin
         pc_d = redirect_pc;
      end else if (advance_en) begin
         // Wraps modulo 2^ADDR_WIDTH; the out-of-range halt stops fetch first.
         pc_d = pc_q + ADDR_WIDTH'(1);
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the word-addressed PC, drives the combinational imem
// address and registers the returned instruction into a single decode slot.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    INST_WIDTH = 32,
   parameter int                    IMEM_DEPTH = 1024,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  halt_req,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [INST_WIDTH-1:0] imem_instr,
   instruction_fetch_unit_if.master dec,
   output logic [1:0]            fetch_state,
   output logic                  pc_oob
);

   localparam logic [INST_WIDTH-1:0] NOP_W       = INST_WIDTH'(NOP);
   localparam logic [ADDR_WIDTH:0]   DEPTH_LIMIT = (ADDR_WIDTH+1)'(IMEM_DEPTH);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  if_valid_q, if_valid_d;
   logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
   logic [INST_WIDTH-1:0] if_instr_q, if_instr_d;
   logic                  pc_oob_q, pc_oob_d;

   logic in_fetch;
   logic slot_free;
   logic pc_in_range;
   logic redirect_en;
   logic oob_hit;
   logic capture;

   always_comb begin
      in_fetch    = (state_q == FETCH);
      slot_free   = !if_valid_q || dec.if_ready;
      pc_in_range = ({1'b0, pc_q} < DEPTH_LIMIT);
      redirect_en = in_fetch && redirect_valid;
      // A redirect replaces the PC before it is ever checked against the depth.
      oob_hit     = in_fetch && !redirect_valid && !pc_in_range;
      capture     = in_fetch && !redirect_valid && pc_in_range && slot_free;
   end

   fetch_pc_gen #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_pc_gen (
      .pc_q        (pc_q),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .advance_en  (capture),
      .pc_d        (pc_d)
   );

   always_comb begin
      state_d    = state_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      pc_oob_d   = pc_oob_q | oob_hit;

      // Flush wins even over a slot that decode is still stalling on.
      if (redirect_en) begin
         if_valid_d = 1'b0;
      end else if (capture) begin
         if_valid_d = 1'b1;
         if_pc_d    = pc_q;
         if_instr_d = imem_instr;
      end else if (slot_free) begin
         if_valid_d = 1'b0;
      end

      case (state_q)
         IDLE, HALTED: if (start) state_d = FETCH;
         FETCH:        if (halt_req || oob_hit) state_d = HALTED;
         default:      state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_instr_q <= NOP_W;
         pc_oob_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         pc_oob_q   <= pc_oob_d;
      end
   end

   assign imem_addr    = pc_q;
   assign dec.if_valid = if_valid_q;
   assign dec.if_pc    = if_pc_q;
   assign dec.if_instr = if_instr_q;
   assign fetch_state  = state_q;
   assign pc_oob       = pc_oob_q;

endmodule
